// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter
//   Owns the single-port playfield RAM (COLS x ROWS cells, KIND_W bits per
//   cell) and shares it between the VGA display path and the game logic.
//   Display fetches normally win; a saturating wait counter lets a game
//   request override the display once it has lost MAX_WAIT times.
//
// Handshakes (one rule for the whole block):
//   - game side: game_req is held with stable fields until game_gnt. game_gnt
//     is a one-cycle pulse in the cycle the access issues. For reads,
//     game_rvalid pulses with game_rdata in the following cycle.
//   - display side: a fetch issues whenever disp_valid=1 and the coordinate
//     differs from the last fetched one; disp_kind updates 2 cycles later.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   disp_valid/disp_x/disp_y     display cell request
//   disp_kind                    kind of the last fetched display cell
//   game_req/we/x/y/wdata        game access request
//   game_gnt                     request accepted this cycle
//   game_rvalid/game_rdata       read return, one cycle after the grant
//   ram_en/we/addr/wdata         RAM command, driven combinationally in IDLE
//   ram_rdata                    RAM read data, one cycle after ram_en
//   dbg_state                    current FSM state (0 IDLE, 1 DISP, 2 GAME)
module board_ram_arbiter #(
    parameter int COLS     = 10,
    parameter int ROWS     = 20,
    parameter int KIND_W   = 4,
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              disp_valid,
    input  logic [3:0]        disp_x,
    input  logic [4:0]        disp_y,
    output logic [KIND_W-1:0] disp_kind,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [3:0]        game_x,
    input  logic [4:0]        game_y,
    input  logic [KIND_W-1:0] game_wdata,
    output logic              game_gnt,
    output logic              game_rvalid,
    output logic [KIND_W-1:0] game_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [KIND_W-1:0] ram_wdata,
    input  logic [KIND_W-1:0] ram_rdata,
    output logic [1:0]        dbg_state
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DISP = 2'd1,
        S_GAME = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_tag_vld;
    logic [8:0]          r_tag;
    logic [WAIT_W-1:0]   r_wait;
    logic [KIND_W-1:0]   r_disp_kind;
    logic                r_oor;       // access in flight targets a cell off the board
    logic                r_game_rd;   // access in flight is a game read

    logic                w_disp_in;
    logic                w_game_in;
    logic [ADDR_W-1:0]   w_disp_addr;
    logic [ADDR_W-1:0]   w_game_addr;
    logic                w_pend;
    logic                w_wait_full;
    logic                w_pick_game;
    logic                w_pick_disp;

    logic                w_gnt;
    logic                w_rvalid;
    logic [KIND_W-1:0]   w_rdata;
    logic                w_en;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [KIND_W-1:0]   w_wdata;

    assign w_disp_in   = (32'(disp_x) < COLS) && (32'(disp_y) < ROWS);
    assign w_game_in   = (32'(game_x) < COLS) && (32'(game_y) < ROWS);
    // Row product first, then the column, all in ADDR_W unsigned arithmetic.
    assign w_disp_addr = ADDR_W'(disp_y) * ADDR_W'(COLS) + ADDR_W'(disp_x);
    assign w_game_addr = ADDR_W'(game_y) * ADDR_W'(COLS) + ADDR_W'(game_x);

    assign w_pend      = disp_valid && (!r_tag_vld || ({disp_y, disp_x} != r_tag));
    assign w_wait_full = (r_wait >= WAIT_W'(MAX_WAIT));
    // A starved game request beats the display; otherwise the game only wins
    // when the display has nothing to fetch.
    assign w_pick_game = (r_state == S_IDLE) && game_req && (w_wait_full || !w_pend);
    assign w_pick_disp = (r_state == S_IDLE) && w_pend && !w_pick_game;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 1'b0;
        w_rvalid    = 1'b0;
        w_rdata     = '0;
        w_en        = 1'b0;
        w_we        = 1'b0;
        w_addr      = '0;
        w_wdata     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_game) begin
                    w_state_nxt = S_GAME;
                    w_gnt       = 1'b1;
                    // Off-board game accesses are granted but never reach the RAM.
                    w_en        = w_game_in;
                    w_we        = w_game_in && game_we;
                    w_addr      = w_game_in ? w_game_addr : '0;
                    w_wdata     = (w_game_in && game_we) ? game_wdata : '0;
                end else if (w_pick_disp) begin
                    w_state_nxt = S_DISP;
                    w_en        = w_disp_in;
                    w_addr      = w_disp_in ? w_disp_addr : '0;
                end
            end
            S_DISP: begin
                w_state_nxt = S_IDLE;
            end
            S_GAME: begin
                w_state_nxt = S_IDLE;
                w_rvalid    = r_game_rd;
                w_rdata     = (r_game_rd && !r_oor) ? ram_rdata : '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Outputs are held at zero for the whole time reset is asserted,
        // including the combinational RAM command path.
        if (!reset_n) begin
            w_gnt    = 1'b0;
            w_rvalid = 1'b0;
            w_rdata  = '0;
            w_en     = 1'b0;
            w_we     = 1'b0;
            w_addr   = '0;
            w_wdata  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_vld   <= 1'b0;
            r_tag       <= '0;
            r_wait      <= '0;
            r_disp_kind <= '0;
            r_oor       <= 1'b0;
            r_game_rd   <= 1'b0;
        end else begin
            if (w_pick_game) begin
                r_oor     <= !w_game_in;
                r_game_rd <= !game_we;
            end else if (w_pick_disp) begin
                r_oor     <= !w_disp_in;
                r_game_rd <= 1'b0;
            end

            if (!disp_valid) begin
                r_tag_vld <= 1'b0;
            end else if (w_pick_disp) begin
                r_tag_vld <= 1'b1;
                r_tag     <= {disp_y, disp_x};
            end

            // Blanking wins over a fetch that is just completing.
            if (!disp_valid) begin
                r_disp_kind <= '0;
            end else if (r_state == S_DISP) begin
                r_disp_kind <= r_oor ? '0 : ram_rdata;
            end

            if (!game_req || w_pick_game) begin
                r_wait <= '0;
            end else if ((r_state == S_IDLE) && !w_wait_full) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

    assign disp_kind   = r_disp_kind;
    assign game_gnt    = w_gnt;
    assign game_rvalid = w_rvalid;
    assign game_rdata  = w_rdata;
    assign ram_en      = w_en;
    assign ram_we      = w_we;
    assign ram_addr    = w_addr;
    assign ram_wdata   = w_wdata;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_board_ram_arbiter.sv
module tb_board_ram_arbiter;

    localparam int COLS     = 10;
    localparam int ROWS     = 20;
    localparam int KIND_W   = 4;
    localparam int ADDR_W   = 8;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              disp_valid;
    logic [3:0]        disp_x;
    logic [4:0]        disp_y;
    logic [KIND_W-1:0] disp_kind;
    logic              game_req;
    logic              game_we;
    logic [3:0]        game_x;
    logic [4:0]        game_y;
    logic [KIND_W-1:0] game_wdata;
    logic              game_gnt;
    logic              game_rvalid;
    logic [KIND_W-1:0] game_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [KIND_W-1:0] ram_wdata;
    logic [KIND_W-1:0] ram_rdata;
    logic [1:0]        dbg_state;

    board_ram_arbiter #(
        .COLS(COLS), .ROWS(ROWS), .KIND_W(KIND_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .disp_valid(disp_valid), .disp_x(disp_x), .disp_y(disp_y), .disp_kind(disp_kind),
        .game_req(game_req), .game_we(game_we), .game_x(game_x), .game_y(game_y),
        .game_wdata(game_wdata), .game_gnt(game_gnt), .game_rvalid(game_rvalid),
        .game_rdata(game_rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters / check ----------------
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- RAM environment (address-indexed) ----------------
    logic [KIND_W-1:0] pre [0:255];
    logic              loading;
    logic [KIND_W-1:0] mem [0:255];

    always @(posedge clk) begin
        if (loading) begin
            for (int i = 0; i < 256; i++) mem[i] <= pre[i];
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    // ---------------- behavioural model (cell-indexed) ----------------
    // The board is a 2-D array of cells; the arbiter is either free or busy
    // completing one job (display fetch, game read, game write).
    logic [KIND_W-1:0] cells [0:ROWS-1][0:COLS-1];
    logic              m_busy;
    int                m_job;      // 1 display fetch, 2 game read, 3 game write
    logic              m_oor;
    int                m_x, m_y;
    logic              m_tag_ok;
    int                m_tx, m_ty;
    int                m_wait;
    logic [KIND_W-1:0] m_kind;
    logic              m_granted;
    logic              d_game, d_disp;

    // Compare process: expected outputs from the model, checked every cycle.
    always @(negedge clk) begin
        int gx, gy, dx, dy;
        logic pend, gin, din;
        logic e_gnt, e_rvalid, e_en, e_we;
        logic [KIND_W-1:0] e_rdata, e_wdata, e_kind;
        logic [ADDR_W-1:0] e_addr;
        #2;
        gx = int'(game_x); gy = int'(game_y);
        dx = int'(disp_x); dy = int'(disp_y);
        gin = (gx < COLS) && (gy < ROWS);
        din = (dx < COLS) && (dy < ROWS);
        e_gnt = 1'b0; e_rvalid = 1'b0; e_en = 1'b0; e_we = 1'b0;
        e_rdata = '0; e_wdata = '0; e_kind = '0; e_addr = '0;
        d_game = 1'b0; d_disp = 1'b0;
        if (reset_n) begin
            e_kind = m_kind;
            if (!m_busy) begin
                pend   = disp_valid && (!m_tag_ok || dx != m_tx || dy != m_ty);
                d_game = game_req && (m_wait >= MAX_WAIT || !pend);
                d_disp = pend && !d_game;
                if (d_game) begin
                    e_gnt   = 1'b1;
                    e_en    = gin;
                    e_we    = gin && game_we;
                    e_addr  = gin ? ADDR_W'(gy * COLS + gx) : '0;
                    e_wdata = (gin && game_we) ? game_wdata : '0;
                end else if (d_disp) begin
                    e_en   = din;
                    e_addr = din ? ADDR_W'(dy * COLS + dx) : '0;
                end
            end else if (m_job == 2) begin
                e_rvalid = 1'b1;
                e_rdata  = m_oor ? '0 : cells[m_y][m_x];
            end
        end
        check("game_gnt",    16'(game_gnt),    16'(e_gnt));
        check("game_rvalid", 16'(game_rvalid), 16'(e_rvalid));
        check("game_rdata",  16'(game_rdata),  16'(e_rdata));
        check("ram_en",      16'(ram_en),      16'(e_en));
        check("ram_we",      16'(ram_we),      16'(e_we));
        check("ram_addr",    16'(ram_addr),    16'(e_addr));
        check("ram_wdata",   16'(ram_wdata),   16'(e_wdata));
        check("disp_kind",   16'(disp_kind),   16'(e_kind));
    end

    // Model state advance on the active edge.
    always @(posedge clk) begin
        if (loading) begin
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++)
                    cells[y][x] <= pre[y * COLS + x];
        end
        if (!reset_n) begin
            m_busy <= 1'b0; m_job <= 0; m_oor <= 1'b0; m_tag_ok <= 1'b0;
            m_wait <= 0; m_kind <= '0; m_granted <= 1'b0;
        end else begin
            m_granted <= d_game;
            if (!m_busy) begin
                if (d_game) begin
                    m_busy <= 1'b1;
                    m_job  <= game_we ? 3 : 2;
                    m_oor  <= !((int'(game_x) < COLS) && (int'(game_y) < ROWS));
                    m_x    <= int'(game_x);
                    m_y    <= int'(game_y);
                    if (game_we && (int'(game_x) < COLS) && (int'(game_y) < ROWS))
                        cells[game_y][game_x] <= game_wdata;
                end else if (d_disp) begin
                    m_busy   <= 1'b1;
                    m_job    <= 1;
                    m_oor    <= !((int'(disp_x) < COLS) && (int'(disp_y) < ROWS));
                    m_x      <= int'(disp_x);
                    m_y      <= int'(disp_y);
                    m_tx     <= int'(disp_x);
                    m_ty     <= int'(disp_y);
                    m_tag_ok <= 1'b1;
                end
            end else begin
                m_busy <= 1'b0;
                m_job  <= 0;
                if (m_job == 1) m_kind <= m_oor ? '0 : cells[m_y][m_x];
            end
            if (!game_req || d_game) m_wait <= 0;
            else if (!m_busy) m_wait <= (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
            if (!disp_valid) begin
                m_tag_ok <= 1'b0;
                m_kind   <= '0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic game_set(input logic req, input logic we, input int x, input int y, input int d);
        game_req   = req;
        game_we    = we;
        game_x     = 4'(x);
        game_y     = 5'(y);
        game_wdata = KIND_W'(d);
    endtask

    task automatic disp_set(input logic v, input int x, input int y);
        disp_valid = v;
        disp_x     = 4'(x);
        disp_y     = 5'(y);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        logic got;
        for (int i = 0; i < 256; i++) pre[i] = KIND_W'($urandom_range(0, 15));
        pre[23] = 4'd7;
        loading = 1'b1;
        reset_n = 1'b0;
        disp_set(1'b1, 3, 2);
        game_set(1'b1, 1'b0, 1, 1, 0);

        // Reset holds every output at 0 even with requests present.
        repeat (3) tick();
        #3;
        check("rst_ram_en",    16'(ram_en),      16'd0);
        check("rst_gnt",       16'(game_gnt),    16'd0);
        check("rst_rvalid",    16'(game_rvalid), 16'd0);
        check("rst_disp_kind", 16'(disp_kind),   16'd0);
        check("rst_dbg_state", 16'(dbg_state),   16'd0);
        tick();
        loading = 1'b0;
        disp_set(1'b0, 0, 0);
        game_set(1'b0, 1'b0, 0, 0, 0);
        tick();
        reset_n = 1'b1;

        // Display fetch of (3,2).
        tick(); disp_set(1'b1, 3, 2); #3;
        check("disp_en",   16'(ram_en),   16'd1);
        check("disp_addr", 16'(ram_addr), 16'd23);
        check("disp_we",   16'(ram_we),   16'd0);
        tick(); #3;
        check("disp_busy_en", 16'(ram_en), 16'd0);
        tick(); #3;
        check("disp_kind_2cyc", 16'(disp_kind), 16'd7);
        check("disp_hold_en",   16'(ram_en),    16'd0);

        // Game write (9,19)=5 then read back.
        tick(); game_set(1'b1, 1'b1, 9, 19, 5); #3;
        check("wr_gnt",  16'(game_gnt), 16'd1);
        check("wr_addr", 16'(ram_addr), 16'd199);
        check("wr_we",   16'(ram_we),   16'd1);
        tick(); game_set(1'b0, 1'b0, 9, 19, 0); #3;
        check("wr_no_rvalid", 16'(game_rvalid), 16'd0);
        tick(); game_set(1'b1, 1'b0, 9, 19, 0); #3;
        check("rd_gnt", 16'(game_gnt), 16'd1);
        tick(); game_set(1'b0, 1'b0, 0, 0, 0); #3;
        check("rd_rvalid", 16'(game_rvalid), 16'd1);
        check("rd_rdata",  16'(game_rdata),  16'd5);

        // Reset in the middle of a game read.
        tick(); game_set(1'b1, 1'b0, 3, 2, 0); #3;
        check("mid_gnt", 16'(game_gnt), 16'd1);
        tick(); game_set(1'b0, 1'b0, 0, 0, 0); reset_n = 1'b0; #3;
        check("mid_rst_rvalid", 16'(game_rvalid), 16'd0);
        check("mid_rst_kind",   16'(disp_kind),   16'd0);
        tick(); reset_n = 1'b1; #3;
        check("post_rst_en",   16'(ram_en),   16'd1);
        check("post_rst_addr", 16'(ram_addr), 16'd23);
        tick(); tick(); #3;
        check("post_rst_kind", 16'(disp_kind), 16'd7);

        // Off-board accesses and display blanking.
        tick(); game_set(1'b1, 1'b1, 10, 0, 9); #3;
        check("oor_wr_gnt", 16'(game_gnt), 16'd1);
        check("oor_wr_en",  16'(ram_en),   16'd0);
        tick(); game_set(1'b0, 1'b0, 0, 0, 0);
        tick(); game_set(1'b1, 1'b0, 0, 20, 0); #3;
        check("oor_rd_gnt", 16'(game_gnt), 16'd1);
        check("oor_rd_en",  16'(ram_en),   16'd0);
        tick(); game_set(1'b0, 1'b0, 0, 0, 0); #3;
        check("oor_rd_rvalid", 16'(game_rvalid), 16'd1);
        check("oor_rd_rdata",  16'(game_rdata),  16'd0);
        tick(); disp_set(1'b0, 3, 2); #3;
        check("blank_before_edge", 16'(disp_kind), 16'd7);
        tick(); #3;
        check("blank_after_edge", 16'(disp_kind), 16'd0);
        tick(); disp_set(1'b1, 10, 0); #3;
        check("oor_disp_en", 16'(ram_en), 16'd0);
        tick(); tick(); #3;
        check("oor_disp_kind", 16'(disp_kind), 16'd0);

        // Simultaneous arrival: display first, game on the next free cycle.
        tick(); disp_set(1'b1, 4, 2); game_set(1'b1, 1'b0, 3, 2, 0); #3;
        check("sim_disp_en",   16'(ram_en),   16'd1);
        check("sim_disp_addr", 16'(ram_addr), 16'd24);
        check("sim_gnt0",      16'(game_gnt), 16'd0);
        tick(); #3;
        check("sim_gnt1", 16'(game_gnt), 16'd0);
        tick(); #3;
        check("sim_gnt2", 16'(game_gnt), 16'd1);
        tick(); game_set(1'b0, 1'b0, 0, 0, 0);

        // Contention: the display moves every 2 cycles while the game waits.
        tick(); game_set(1'b1, 1'b0, 5, 5, 0);
        got = 1'b0;
        k = 0;
        while (k < 20 && !got) begin
            if (k > 0) tick();
            if (k % 2 == 0) disp_set(1'b1, (k / 2) % 10, 7);
            #3;
            if (game_gnt) got = 1'b1;
            else k++;
        end
        check("cont_gnt_seen",  16'(got), 16'd1);
        check("cont_gnt_cycle", 16'(k),   16'(2 * MAX_WAIT));
        tick(); game_set(1'b0, 1'b0, 0, 0, 0);
        tick(); #3;
        check("cont_disp_next_en",   16'(ram_en),   16'd1);
        check("cont_disp_next_addr", 16'(ram_addr), 16'd74);
        check("cont_disp_next_gnt",  16'(game_gnt), 16'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int r;
            tick();
            reset_n = ($urandom_range(0, 199) != 0);
            r = $urandom_range(0, 9);
            if (r == 0) disp_valid = 1'b0;
            else if (r < 4) disp_set(1'b1, $urandom_range(0, 11), $urandom_range(0, 21));
            else disp_valid = 1'b1;
            if (game_req && !m_granted) begin
                if ($urandom_range(0, 99) < 3) game_req = 1'b0;
            end else if ($urandom_range(0, 9) < 4) begin
                game_set(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 11),
                         $urandom_range(0, 21), $urandom_range(0, 15));
            end else begin
                game_req = 1'b0;
            end
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
